uart_rx_cfg: RTL

Configurable UART receiver for the serial I/O path, clocked by the shared baud-rate generator's s_tick oversampling strobe.
It generalises the 8N1 receiver with the following features:
- parametrised data width and oversampling ratio
- runtime parity (none/even/odd) and 1 or 2 stop bits
- start-bit glitch rejection, 2-flop rx synchroniser
- parity, framing and break error reporting
Received bytes go to the downstream RX FIFO / ALU interface on a one-cycle rx_done_tick.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_cfg_if.sv | 16 +
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx_cfg.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and default
// frame geometry used by the receiver, transmitter and baud generator.
package uart_pkg;

   localparam int OS_DEF      = 16;
   localparam int NB_DATA_DEF = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_START  = ST_START,
      S_DATA   = ST_DATA,
      S_PARITY = ST_PARITY,
      S_STOP   = ST_STOP
   } rx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Mode 2'b11 is deliberately folded into "no parity bit on the line".
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver result bus towards the RX FIFO / ALU: a one-cycle done strobe
// qualifying the held data word and error flags.
interface uart_rx_cfg_if #(
   parameter int NB_DATA = uart_pkg::NB_DATA_DEF
);
   logic               rx_done_tick;
   logic [NB_DATA-1:0] dout;
   logic               parity_err;
   logic               frame_err;
   logic               break_det;

   modport master (output rx_done_tick, output dout, output parity_err,
                   output frame_err, output break_det);
   modport slave  (input rx_done_tick, input dout, input parity_err,
                   input frame_err, input break_det);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous serial-line inputs; resets to the
// idle-high line level so no false start edge appears out of reset.
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: NB_DATA data bits, runtime
// parity and stop-bit count, glitch rejection and error/break reporting.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int OS      = OS_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx,
   input  logic          s_tick,
   input  logic [1:0]    parity_mode,
   input  logic          stop2,
   uart_rx_cfg_if.master rx_bus
);
   localparam int SW = $clog2(OS);
   localparam int NW = $clog2(NB_DATA);
   localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
   localparam logic [SW-1:0] S_ONE  = SW'(1);
   localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);
   localparam logic [NW-1:0] N_ONE  = NW'(1);

   logic w_rx_s;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (rx),
      .o_q   (w_rx_s)
   );

   rx_state_t          r_state;
   logic [SW-1:0]      r_s_cnt;
   logic [NW-1:0]      r_n_cnt;
   logic [NB_DATA-1:0] r_sh;
   logic               r_pbit;
   logic [1:0]         r_par_mode;
   logic               r_stop2;
   logic               r_stop_idx;
   logic               r_ferr;
   logic               r_armed;
   logic               r_done;
   logic [NB_DATA-1:0] r_dout;
   logic               r_perr_o;
   logic               r_ferr_o;
   logic               r_brk_o;

   logic w_par_on;
   logic w_perr;
   logic w_ferr_now;
   logic w_all_zero;

   assign w_par_on   = par_enabled(r_par_mode);
   // Even: data^pbit must be 0; odd: it must be 1.
   assign w_perr     = w_par_on && ((^{r_sh, r_pbit}) != (r_par_mode == PAR_ODD));
   assign w_ferr_now = r_ferr | ~w_rx_s;
   assign w_all_zero = (r_sh == '0) && (!w_par_on || !r_pbit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_s_cnt    <= '0;
         r_n_cnt    <= '0;
         r_sh       <= '0;
         r_pbit     <= 1'b0;
         r_par_mode <= PAR_NONE;
         r_stop2    <= 1'b0;
         r_stop_idx <= 1'b0;
         r_ferr     <= 1'b0;
         r_armed    <= 1'b1;
         r_done     <= 1'b0;
         r_dout     <= '0;
         r_perr_o   <= 1'b0;
         r_ferr_o   <= 1'b0;
         r_brk_o    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            // Arming only happens in IDLE, so a line stuck low after a
            // break cannot retrigger until it has been seen high again.
            S_IDLE: begin
               if (w_rx_s) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_armed    <= 1'b0;
                  r_state    <= S_START;
                  r_s_cnt    <= '0;
                  r_par_mode <= parity_mode;
                  r_stop2    <= stop2;
                  r_stop_idx <= 1'b0;
                  r_ferr     <= 1'b0;
               end
            end
            S_START: begin
               if (s_tick) begin
                  if (r_s_cnt == S_HALF) begin
                     r_s_cnt <= '0;
                     if (!w_rx_s) begin
                        r_state <= S_DATA;
                        r_n_cnt <= '0;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_s_cnt <= r_s_cnt + S_ONE;
                  end
               end
            end
            S_DATA: begin
               if (s_tick) begin
                  if (r_s_cnt == S_LAST) begin
                     r_s_cnt <= '0;
                     r_sh    <= {w_rx_s, r_sh[NB_DATA-1:1]};
                     if (r_n_cnt == N_LAST)
                        r_state <= w_par_on ? S_PARITY : S_STOP;
                     else
                        r_n_cnt <= r_n_cnt + N_ONE;
                  end else begin
                     r_s_cnt <= r_s_cnt + S_ONE;
                  end
               end
            end
            S_PARITY: begin
               if (s_tick) begin
                  if (r_s_cnt == S_LAST) begin
                     r_s_cnt <= '0;
                     r_pbit  <= w_rx_s;
                     r_state <= S_STOP;
                  end else begin
                     r_s_cnt <= r_s_cnt + S_ONE;
                  end
               end
            end
            S_STOP: begin
               if (s_tick) begin
                  if (r_s_cnt == S_LAST) begin
                     r_s_cnt <= '0;
                     if (r_stop2 && !r_stop_idx) begin
                        r_stop_idx <= 1'b1;
                        r_ferr     <= w_ferr_now;
                     end else begin
                        r_state  <= S_IDLE;
                        r_done   <= 1'b1;
                        r_dout   <= r_sh;
                        r_perr_o <= w_perr;
                        r_ferr_o <= w_ferr_now;
                        r_brk_o  <= w_ferr_now && w_all_zero;
                     end
                  end else begin
                     r_s_cnt <= r_s_cnt + S_ONE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_bus.rx_done_tick = r_done;
   assign rx_bus.dout         = r_dout;
   assign rx_bus.parity_err   = r_perr_o;
   assign rx_bus.frame_err    = r_ferr_o;
   assign rx_bus.break_det    = r_brk_o;
endmodule
